// File: rtl/ro_meas_pkg.sv
// Shared types and default parameters for the ring-oscillator measurement controller.
package ro_meas_pkg;

    localparam int DEF_CNT_W         = 64;
    localparam int DEF_WIN_W         = 32;
    localparam int DEF_SEQ_W         = 16;
    localparam int DEF_CLEAR_CYCLES  = 4;
    localparam int DEF_SETTLE_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_CAPTURE
    } ro_state_e;

endpackage

// File: rtl/ro_meas_timer.sv
// Loadable down-counter; done is high once the count has reached zero.
// Loading N-1 on a state entry gives exactly N cycles in that state.
module ro_meas_timer #(
    parameter int WIN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIN_W-1:0] load_val,
    output logic             done
);

    logic [WIN_W-1:0] cnt_q;
    logic [WIN_W-1:0] cnt_d;

    // next count: load wins, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: clear counter, enable oscillator for a
// window, let it settle, capture the count into a valid/ready output slot.
//
// state   | meaning
// IDLE    | counter held in reset, waiting for start
// CLEAR   | counter held in reset for CLEAR_CYCLES
// RUN     | oscillator enabled for max(window,1) cycles
// SETTLE  | oscillator stopped, waiting for the count to freeze
// CAPTURE | load count into the output slot (waits while the slot is full)
module ro_measure_ctrl
    import ro_meas_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int WIN_W         = DEF_WIN_W,
    parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SEQ_W         = DEF_SEQ_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             ro_enable,
    output logic             cnt_reset,
    output logic             busy,
    output logic [CNT_W-1:0] sample_data,
    output logic [SEQ_W-1:0] sample_seq,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             stalled
);

    ro_state_e        state_q,     state_d;
    logic [WIN_W-1:0] win_q,       win_d;
    logic [SEQ_W-1:0] seq_q,       seq_d;
    logic [CNT_W-1:0] s_data_q,    s_data_d;
    logic [SEQ_W-1:0] s_seq_q,     s_seq_d;
    logic             s_valid_q,   s_valid_d;
    logic             stalled_q,   stalled_d;
    logic             ro_enable_q, ro_enable_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             busy_q,      busy_d;

    logic             tmr_load;
    logic [WIN_W-1:0] tmr_val;
    logic             tmr_done;

    ro_meas_timer #(.WIN_W(WIN_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // next state, timer loads, output slot and registered-output targets
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        seq_d     = seq_q;
        s_data_d  = s_data_q;
        s_seq_d   = s_seq_q;
        s_valid_d = s_valid_q;
        stalled_d = stalled_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        if (s_valid_q && sample_ready) begin
            s_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_d     = window_len;
                    stalled_d = 1'b0;
                    state_d   = ST_CLEAR;
                    tmr_load  = 1'b1;
                    tmr_val   = WIN_W'(CLEAR_CYCLES - 1);
                end
            end
            ST_CLEAR: begin
                if (tmr_done) begin
                    state_d  = ST_RUN;
                    tmr_load = 1'b1;
                    // a zero window still gets one enable cycle
                    tmr_val  = (win_q == '0) ? '0 : win_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (tmr_done) begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = WIN_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!s_valid_q || sample_ready) begin
                    s_data_d  = cnt_val;
                    s_seq_d   = seq_q;
                    s_valid_d = 1'b1;
                    seq_d     = seq_q + 1'b1;
                    if (continuous) begin
                        win_d    = window_len;
                        state_d  = ST_CLEAR;
                        tmr_load = 1'b1;
                        tmr_val  = WIN_W'(CLEAR_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    stalled_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ro_enable_d = (state_d == ST_RUN);
        cnt_reset_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
        busy_d      = (state_d != ST_IDLE);
    end

    // state and output registers; reset drops ro_enable immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            seq_q       <= '0;
            s_data_q    <= '0;
            s_seq_q     <= '0;
            s_valid_q   <= 1'b0;
            stalled_q   <= 1'b0;
            ro_enable_q <= 1'b0;
            cnt_reset_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            seq_q       <= seq_d;
            s_data_q    <= s_data_d;
            s_seq_q     <= s_seq_d;
            s_valid_q   <= s_valid_d;
            stalled_q   <= stalled_d;
            ro_enable_q <= ro_enable_d;
            cnt_reset_q <= cnt_reset_d;
            busy_q      <= busy_d;
        end
    end

    assign ro_enable    = ro_enable_q;
    assign cnt_reset    = cnt_reset_q;
    assign busy         = busy_q;
    assign sample_data  = s_data_q;
    assign sample_seq   = s_seq_q;
    assign sample_valid = s_valid_q;
    assign stalled      = stalled_q;

endmodule
